pc_sequencer: RTL and testbench

- Fetch/PC controller for the RV32I core.
- Owns the PC register and runs a single-outstanding instruction-memory request/grant/response handshake.
- Presents fetched instructions to decode with a valid/ready handshake.
- Consumes the branch unit's NextPCSrc decision (with the target from execute) to redirect the PC and flush younger work.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_sequencer_branch_stats.sv | 44 ++++
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared encodings and constants for the RV32I fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_branch_stats.sv
// ============================================================================
//  Module      : branch_stats
//  Description : Saturating counters of resolved and taken control-flow ops.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module branch_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic             taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_tk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt <= '0;
            r_tk_cnt <= '0;
        end else begin
            if (br_valid && !(&r_br_cnt)) begin
                r_br_cnt <= r_br_cnt + C_ONE;
            end
            if (br_valid && taken && !(&r_tk_cnt)) begin
                r_tk_cnt <= r_tk_cnt + C_ONE;
            end
        end
    end

    assign br_count    = r_br_cnt;
    assign taken_count = r_tk_cnt;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : PC owner and single-outstanding fetch sequencer with branch
//                redirect. PC_SEQ_BRANCH_STATS_EN adds branch counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             dec_ready,
    input  logic             br_valid,
    input  logic             next_pc_src,
    input  logic [31:0]      br_target,
    output logic             flush,
    output logic             misalign,
    output logic [31:0]      pc
`ifdef PC_SEQ_BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
`endif
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_pend;
    logic        r_drop;
    logic        r_imem_req;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_flush;
    logic        r_misalign;

    logic        w_redirect;
    logic [31:0] w_tgt;

    assign w_redirect = br_valid & next_pc_src;
    assign w_tgt      = align_word(br_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= RESET_PC;
            r_pend       <= 1'b0;
            r_drop       <= 1'b0;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= 32'h0000_0000;
            r_flush      <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_flush    <= w_redirect;
            r_misalign <= w_redirect & (|br_target[1:0]);
            case (r_state)
                IDLE: begin
                    if (w_redirect) begin
                        r_pc <= w_tgt;
                    end
                    r_state    <= REQ;
                    r_imem_req <= 1'b1;
                end
                REQ: begin
                    // The live request must not move, so the target waits aside.
                    if (w_redirect) begin
                        r_pend    <= 1'b1;
                        r_pend_pc <= w_tgt;
                        r_drop    <= 1'b1;
                    end
                    if (imem_gnt) begin
                        r_state    <= WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_redirect) begin
                        r_pc   <= w_tgt;
                        r_pend <= 1'b0;
                        r_drop <= ~imem_rvalid;
                        if (imem_rvalid) begin
                            r_state    <= REQ;
                            r_imem_req <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop     <= 1'b0;
                            r_state    <= REQ;
                            r_imem_req <= 1'b1;
                            if (r_pend) begin
                                r_pc   <= r_pend_pc;
                                r_pend <= 1'b0;
                            end
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= r_pc;
                            r_pc         <= r_pc + PC_INC;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_redirect || dec_ready) begin
                        if (w_redirect) begin
                            r_pc <= w_tgt;
                        end
                        r_inst_valid <= 1'b0;
                        r_state      <= REQ;
                        r_imem_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign flush      = r_flush;
    assign misalign   = r_misalign;

`ifdef PC_SEQ_BRANCH_STATS_EN
    branch_stats #(
        .CNT_W       (CNT_W)
    ) u_branch_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .taken       (next_pc_src),
        .br_count    (br_count),
        .taken_count (taken_count)
    );
`else
    // Counters are absent; CNT_W stays so parameter overrides remain portable.
    if (CNT_W > 0) begin : g_no_branch_stats
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Randomised scoreboard bench for pc_sequencer with a memory
//                model and a program-order reference of delivered fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, dec_ready;
    logic [31:0] inst, inst_pc, pc;
    logic        br_valid, next_pc_src;
    logic [31:0] br_target;
    logic        flush, misalign;
`ifdef PC_SEQ_BRANCH_STATS_EN
    logic [CNT_W-1:0] br_count, taken_count;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .dec_ready(dec_ready), .br_valid(br_valid), .next_pc_src(next_pc_src),
        .br_target(br_target), .flush(flush), .misalign(misalign), .pc(pc)
`ifdef PC_SEQ_BRANCH_STATS_EN
        , .br_count(br_count), .taken_count(taken_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] q_inst[$];
    logic [1:0]  q_fl[$];
    logic [31:0] m_last;
    int          n_br, n_tk, n_deliv;

    bit          mem_out;
    logic [31:0] mem_addr;
    int          rv_wait, g_wait, gnt_max, rv_max, rdy_pct;
    bit          s_req, s_valid;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
    endtask

    // Account for the rising edge that just passed: memory state and program order.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            mem_out = 1'b0;
            g_wait  = 0;
            q_inst.delete();
            m_last  = RESET_PC;
            q_inst.push_back(RESET_PC);
            n_br = 0;
            n_tk = 0;
        end else begin
            if (imem_rvalid) mem_out = 1'b0;
            if (imem_gnt && s_req) begin
                mem_out  = 1'b1;
                mem_addr = s_addr;
                rv_wait  = $urandom_range(rv_max);
                g_wait   = $urandom_range(gnt_max);
            end
            if (br_valid) begin
                n_br++;
                if (next_pc_src) n_tk++;
            end
            if (br_valid && next_pc_src) begin
                q_inst.delete();
                m_last = {br_target[31:2], 2'b00};
                q_inst.push_back(m_last);
            end else if (s_valid && dec_ready) begin
                m_last = m_last + 32'd4;
                q_inst.push_back(m_last);
            end
        end
    endtask

    task automatic drive(input bit b, input bit t, input logic [31:0] tgt);
        bit red;
        br_valid    = b;
        next_pc_src = t;
        br_target   = tgt;
        dec_ready   = ($urandom_range(99) < rdy_pct);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (rst_n) begin
            if (mem_out) begin
                if (rv_wait == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_addr);
                end else begin
                    rv_wait--;
                end
            end else if (imem_req) begin
                if (g_wait == 0) imem_gnt = 1'b1;
                else g_wait--;
            end
        end
        red = rst_n && b && t;
        q_fl.push_back({red, red && (tgt[1:0] != 2'b00)});
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
    endtask

    initial begin : monitor
        bit          p_valid, p_req, p_rst;
        logic [31:0] p_addr, p_ipc, p_inst, e;
        logic [1:0]  f;
        p_valid = 1'b0; p_req = 1'b0; p_rst = 1'b0;
        p_addr = '0; p_ipc = '0; p_inst = '0;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (q_fl.size() > 0) begin
                f = q_fl.pop_front();
                chk1("flush", flush, f[1]);
                chk1("misalign", misalign, f[0]);
            end
            if (inst_valid && !p_valid) begin
                n_deliv++;
                if (q_inst.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL inst_unexpected: got pc %h, no delivery expected", inst_pc);
                end else begin
                    e = q_inst.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst", inst, mem_word(e));
                end
            end else if (inst_valid && p_valid) begin
                chk("inst_pc_hold", inst_pc, p_ipc);
                chk("inst_hold", inst, p_inst);
            end
            if (p_rst && rst_n && p_req && !imem_gnt) begin
                chk1("req_held", imem_req, 1'b1);
                chk("addr_held", imem_addr, p_addr);
            end
            p_valid = inst_valid; p_req = imem_req; p_rst = rst_n;
            p_addr = imem_addr; p_ipc = inst_pc; p_inst = inst;
        end
    end

    initial begin : stim
        int          first_v, second_v, cnt, d0;
        bit          pv, hit, armed;
        logic [31:0] tgt;
        int          r;
        rst_n = 1'b1;
        br_valid = 1'b0; next_pc_src = 1'b0; br_target = '0; dec_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        gnt_max = 0; rv_max = 0; rdy_pct = 100; g_wait = 0; mem_out = 1'b0;
        m_last = RESET_PC; n_br = 0; n_tk = 0; n_deliv = 0;
        s_req = 1'b0; s_valid = 1'b0; s_addr = '0; mem_addr = '0; rv_wait = 0;
        #1 rst_n = 1'b0;
        #1 reset_checks();
        tick(); drive(0, 0, 32'h0);
        tick(); drive(0, 0, 32'h0);
        tick(); rst_n = 1'b1; drive(0, 0, 32'h0);

        // 0-wait memory, decode always ready: first delivery timing and rate
        first_v = -1; second_v = -1; pv = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (inst_valid && !pv) begin
                if (first_v < 0) first_v = i;
                else if (second_v < 0) second_v = i;
            end
            pv = inst_valid;
            drive(0, 0, 32'h0);
        end
        chk("first_valid_edge", first_v, 3);
        chk("second_valid_edge", second_v, 6);

        // redirect while holding the instruction at 0x8
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (inst_valid && inst_pc == 32'h8) begin
                drive(1, 1, 32'h100);
                hit = 1'b1;
            end else begin
                drive(0, 0, 32'h0);
            end
        end
        chk1("reach_pc8", hit, 1'b1);
        for (int i = 0; i < 8; i++) begin tick(); drive(0, 0, 32'h0); end

        // redirect arriving while a request at 0x10 is being stalled
        tick(); drive(1, 1, 32'h10);
        armed = 1'b0; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!armed && imem_req && imem_addr == 32'h10) begin
                g_wait = 3;
                armed  = 1'b1;
            end
            if (armed) cnt++;
            if (armed && cnt == 3) drive(1, 1, 32'h200);
            else drive(0, 0, 32'h0);
        end
        chk1("stall_req_seen", armed, 1'b1);

        // not-taken resolutions every cycle across all states
        gnt_max = 2; rv_max = 2; rdy_pct = 60;
        for (int i = 0; i < 24; i++) begin tick(); drive(1, 0, $urandom); end

        // misaligned target, then fetch wrap at the top of the address space
        gnt_max = 0; rv_max = 0; rdy_pct = 100;
        tick(); drive(1, 1, 32'h0000_0103);
        for (int i = 0; i < 10; i++) begin tick(); drive(0, 0, 32'h0); end
        d0 = n_deliv;
        tick(); drive(1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 12; i++) begin tick(); drive(0, 0, 32'h0); end
        chk1("wrap_progress", (n_deliv - d0) >= 3, 1'b1);

        // randomised traffic with one mid-run reset
        gnt_max = 3; rv_max = 3; rdy_pct = 70;
        d0 = n_deliv;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (i == 1200) rst_n = 1'b0;
            if (i == 1203) rst_n = 1'b1;
            r = $urandom_range(99);
            case ($urandom_range(9))
                0:       tgt = 32'hFFFF_FFFC | ($urandom & 32'h3);
                1:       tgt = $urandom | 32'h1;
                default: tgt = $urandom & 32'h0000_FFFC;
            endcase
            drive(r < 9, $urandom_range(99) < 60, tgt);
            if (i == 1200) begin
                #1 reset_checks();
            end
        end
        chk1("random_progress", (n_deliv - d0) >= 50, 1'b1);

        // drain with an ideal memory; deliveries must resume within a bound
        gnt_max = 0; rv_max = 0; rdy_pct = 100;
        d0 = n_deliv;
        for (int i = 0; i < 20; i++) begin tick(); drive(0, 0, 32'h0); end
        chk1("drain_progress", n_deliv > d0, 1'b1);

`ifdef PC_SEQ_BRANCH_STATS_EN
        chk("br_count", 32'(br_count), (n_br > 3) ? 32'd3 : 32'(n_br));
        chk("taken_count", 32'(taken_count), (n_tk > 3) ? 32'd3 : 32'(n_tk));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
